// File: rtl/jtag_host.sv
// JTAG host: sequences the TAP from Run-Test/Idle through IR/DR scans or a
// TAP reset and back. It returns the TDO bits captured during the shift ticks.
module jtag_host #(
  parameter int CLK_DIV   = 2,
  parameter int DATA_BITS = 41,
  parameter int LEN_BITS  = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_reset_i,
  input  logic                 req_ir_i,
  input  logic [LEN_BITS-1:0]  req_len_i,
  input  logic [DATA_BITS-1:0] req_data_i,
  output logic                 resp_valid_o,
  output logic [DATA_BITS-1:0] resp_data_o,
  output logic                 jtag_tck_o,
  output logic                 jtag_tms_o,
  output logic                 jtag_tdi_o,
  output logic                 jtag_trst_no,
  input  logic                 jtag_tdo_i
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_STARTUP, ST_HEADER, ST_SHIFT, ST_TAIL, ST_DONE
  } state_e;

  state_e                 state;
  logic [CW-1:0]          div_cnt;
  logic                   tck_hi;
  logic [2:0]             tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [BW-1:0]          len_q;
  logic [DATA_BITS-1:0]   data_q;
  logic [DATA_BITS-1:0]   cap_q;
  logic                   is_ir;
  logic                   cmd_rst;
  logic [BW-1:0]          eff_len;
  logic                   accept;

  assign accept = req_valid_i && req_ready_o;

  // Effective scan length: zero means one bit, oversize requests clamp to the register width.
  always_comb begin
    eff_len = BW'(DATA_BITS);
    if (req_len_i == '0)
      eff_len = BW'(1);
    else if (32'(req_len_i) <= DATA_BITS)
      eff_len = BW'(req_len_i);
  end

  // Command FSM, tick generator and registered JTAG pins. Each tick is a low phase and then a high phase.
  // TMS/TDI for the next tick are loaded when the previous tick's high phase ends.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      tck_hi       <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      len_q        <= '0;
      data_q       <= '0;
      cap_q        <= '0;
      is_ir        <= 1'b0;
      cmd_rst      <= 1'b0;
      req_ready_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      jtag_tck_o   <= 1'b0;
      jtag_tms_o   <= 1'b1;
      jtag_tdi_o   <= 1'b0;
      jtag_trst_no <= 1'b0;
    end else if (!jtag_trst_no) begin
      // first cycle out of reset: release TRST and start the TLR->RTI walk
      jtag_trst_no <= 1'b1;
      state        <= ST_STARTUP;
      cmd_rst      <= 1'b0;
      tick_cnt     <= '0;
      div_cnt      <= '0;
      tck_hi       <= 1'b0;
      jtag_tck_o   <= 1'b0;
      jtag_tms_o   <= 1'b1;
      jtag_tdi_o   <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (accept) begin
            state       <= req_reset_i ? ST_STARTUP : ST_HEADER;
            cmd_rst     <= req_reset_i;
            is_ir       <= req_ir_i;
            len_q       <= eff_len;
            data_q      <= req_data_i;
            cap_q       <= '0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            tck_hi      <= 1'b0;
            req_ready_o <= 1'b0;
            jtag_tck_o  <= 1'b0;
            jtag_tms_o  <= 1'b1;  // every sequence opens with TMS=1
            jtag_tdi_o  <= 1'b0;
          end
        end
        default: begin
          // TDO is stable while TCK is high; take it in the first high cycle
          if (tck_hi && div_cnt == '0 && state == ST_SHIFT)
            cap_q[bit_cnt] <= jtag_tdo_i;
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + CW'(1);
          end else begin
            div_cnt    <= '0;
            tck_hi     <= !tck_hi;
            jtag_tck_o <= !tck_hi;
            if (tck_hi) begin
              tick_cnt   <= tick_cnt + 3'd1;
              jtag_tdi_o <= 1'b0;
              case (state)
                ST_STARTUP: begin
                  if (tick_cnt == 3'd5) begin
                    jtag_tms_o  <= 1'b0;
                    req_ready_o <= 1'b1;
                    if (cmd_rst) begin
                      state        <= ST_DONE;
                      resp_valid_o <= 1'b1;
                      resp_data_o  <= '0;
                    end else begin
                      state <= ST_IDLE;
                    end
                  end else begin
                    jtag_tms_o <= (tick_cnt != 3'd4);
                  end
                end
                ST_HEADER: begin
                  if (tick_cnt == (is_ir ? 3'd3 : 3'd2)) begin
                    state      <= ST_SHIFT;
                    bit_cnt    <= '0;
                    jtag_tms_o <= (len_q == BW'(1));
                    jtag_tdi_o <= data_q[0];
                  end else begin
                    // IR header is 1,1,0,0 and DR header is 1,0,0
                    jtag_tms_o <= is_ir && (tick_cnt == 3'd0);
                  end
                end
                ST_SHIFT: begin
                  if (bit_cnt == len_q - BW'(1)) begin
                    state      <= ST_TAIL;
                    tick_cnt   <= '0;
                    jtag_tms_o <= 1'b1;
                  end else begin
                    bit_cnt    <= bit_cnt + BW'(1);
                    jtag_tms_o <= (bit_cnt + BW'(2) == len_q);
                    jtag_tdi_o <= data_q[bit_cnt + BW'(1)];
                  end
                end
                ST_TAIL: begin
                  jtag_tms_o <= 1'b0;
                  if (tick_cnt == 3'd1) begin
                    state        <= ST_DONE;
                    resp_valid_o <= 1'b1;
                    resp_data_o  <= cap_q;
                    req_ready_o  <= 1'b1;
                  end
                end
                default: state <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
